// File: rtl/rv_fetch_unit_pkg.sv
// Shared constants and state encoding for the RV32I fetch stage.
package rv_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/rv_fetch_unit_if.sv
// Single-outstanding instruction-memory request/response bundle.
interface rv_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/rv_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module rv_if_id_reg
    import rv_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pcD,
    output logic [31:0] o_pc_plus4D,
    output logic [31:0] o_instrD,
    output logic        o_validD
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_validD    <= 1'b0;
            o_instrD    <= NOP_INSTR;
            o_pcD       <= 32'h0000_0000;
            o_pc_plus4D <= 32'h0000_0004;
        end else if (i_flush) begin
            o_validD <= 1'b0;
            o_instrD <= NOP_INSTR;
        end else if (i_stall) begin
            o_validD <= o_validD;
        end else if (i_load) begin
            o_validD    <= 1'b1;
            o_instrD    <= i_instr;
            o_pcD       <= i_pc;
            o_pc_plus4D <= i_pc + 32'd4;
        end else begin
            o_validD <= 1'b0;
            o_instrD <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// Fetch stage: PC, imem request FSM, one-entry hold buffer, IF/ID register.
// Optional perf counters enabled by defining RV_FETCH_PERF_EN.
module rv_fetch_unit
    import rv_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_targetE,
    rv_fetch_unit_if.master  imem,
    output logic [XLEN-1:0]  pcD,
    output logic [XLEN-1:0]  pc_plus4D,
    output logic [XLEN-1:0]  instrD,
    output logic             validD
`ifdef RV_FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_dropped
`endif
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pcF;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] r_hold_pc;
    logic [XLEN-1:0] r_hold_instr;
    logic            r_hold_valid;

    logic            w_req;
    logic            w_fire;
    logic            w_rsp;
    logic            w_to_hold;
    logic            w_hold_load;
    logic            w_dec_load;
    logic [XLEN-1:0] w_dec_pc;
    logic [XLEN-1:0] w_dec_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_state_nxt;
    end

    // A response landing in the redirect cycle is simply dropped, so WAIT
    // only parks in DROP when nothing has come back yet.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   if (w_fire) w_state_nxt = WAIT;
            WAIT: begin
                if (imem.imem_rvalid)  w_state_nxt = FETCH;
                else if (br_taken)     w_state_nxt = DROP;
            end
            DROP:    if (imem.imem_rvalid) w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_comb begin
        w_req = (r_state == FETCH) && !stallF && !r_hold_valid && !br_taken;
        imem.imem_req  = w_req && !rst;
        imem.imem_addr = r_pcF;
    end

    assign w_fire      = w_req && imem.imem_gnt;
    assign w_rsp       = (r_state == WAIT) && imem.imem_rvalid && !br_taken;
    assign w_to_hold   = w_rsp && stallD;
    assign w_hold_load = r_hold_valid && !stallD && !flushD && !br_taken;
    assign w_dec_load  = r_hold_valid || w_rsp;
    assign w_dec_pc    = r_hold_valid ? r_hold_pc    : r_pend_pc;
    assign w_dec_instr = r_hold_valid ? r_hold_instr : imem.imem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcF        <= RESET_PC;
            r_hold_valid <= 1'b0;
        end else begin
            if (br_taken)    r_pcF <= br_targetE;
            else if (w_fire) r_pcF <= r_pcF + 32'd4;

            if (br_taken)         r_hold_valid <= 1'b0;
            else if (w_to_hold)   r_hold_valid <= 1'b1;
            else if (w_hold_load) r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) r_pend_pc <= r_pcF;
        if (w_to_hold) begin
            r_hold_pc    <= r_pend_pc;
            r_hold_instr <= imem.imem_rdata;
        end
    end

    rv_if_id_reg u_if_id (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (br_taken || flushD),
        .i_stall     (stallD),
        .i_load      (w_dec_load),
        .i_pc        (w_dec_pc),
        .i_instr     (w_dec_instr),
        .o_pcD       (pcD),
        .o_pc_plus4D (pc_plus4D),
        .o_instrD    (instrD),
        .o_validD    (validD)
    );

`ifdef RV_FETCH_PERF_EN
    logic w_perf_acc;
    logic w_perf_drop;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Accepted means it reached IF/ID or the hold buffer; a lone flushD loses it.
    assign w_perf_acc  = w_rsp && (stallD || !flushD);
    assign w_perf_drop = imem.imem_rvalid &&
                         ((r_state == DROP) || ((r_state == WAIT) && br_taken));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_dropped <= 32'd0;
        end else begin
            if (w_perf_acc)  perf_fetched <= sat_inc(perf_fetched);
            if (w_perf_drop) perf_dropped <= sat_inc(perf_dropped);
        end
    end
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Scoreboard bench for rv_fetch_unit with a programmable-latency imem model.
module tb_rv_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF, stallD, flushD, br_taken;
    logic [31:0] br_targetE;
    logic [31:0] pcD, pc_plus4D, instrD;
    logic        validD;
`ifdef RV_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif

    rv_fetch_unit_if imem ();

    always #5 clk = ~clk;

    rv_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .br_taken   (br_taken),
        .br_targetE (br_targetE),
        .imem       (imem),
        .pcD        (pcD),
        .pc_plus4D  (pc_plus4D),
        .instrD     (instrD),
        .validD     (validD)
`ifdef RV_FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h00A0_0093 + (a << 8);
    endfunction

    int          mem_lat   = 1;
    bit          pend_v    = 0;
    bit          pend_drop = 0;
    int          pend_cnt  = 0;
    logic [31:0] pend_a    = 32'h0;

    // One clock: memory model responds mem_lat cycles after a grant, and any
    // freshly loaded decode instruction is checked against the scoreboard.
    task automatic step();
        bit          g;
        bit          sd;
        logic [31:0] a;
        exp_t        e;
        #1;
        g  = imem.imem_req && imem.imem_gnt;
        a  = imem.imem_addr;
        sd = stallD;
        @(posedge clk);
        #1;
        if (validD && !sd) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", {31'b0, validD}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", pcD, e.pc);
                chk("sb_instr", instrD, e.instr);
            end
        end
        imem.imem_rvalid = 1'b0;
        if (g) begin
            pend_v    = 1;
            pend_drop = 0;
            pend_a    = a;
            pend_cnt  = mem_lat;
        end
        if (pend_v) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = mem_word(pend_a);
                pend_v = 0;
                if (!pend_drop) sb.push_back('{pc: pend_a, instr: mem_word(pend_a)});
            end
        end
    endtask

    initial begin
        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        br_taken = 1'b0; br_targetE = 32'h0;
        imem.imem_gnt = 1'b1; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;

        #12;
        chk("rst_req", {31'b0, imem.imem_req}, 32'h0);
        chk("rst_valid", {31'b0, validD}, 32'h0);
        chk("rst_instr", instrD, NOP);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_pc4", pc_plus4D, 32'h4);
`ifdef RV_FETCH_PERF_EN
        chk("rst_perf_f", perf_fetched, 32'h0);
        chk("rst_perf_d", perf_dropped, 32'h0);
`endif
        rst = 1'b0;
        #1;
        chk("first_req", {31'b0, imem.imem_req}, 32'h1);
        chk("first_addr", imem.imem_addr, 32'h0);
        step();
        chk("wait_noreq", {31'b0, imem.imem_req}, 32'h0);
        step();
        chk("d0_valid", {31'b0, validD}, 32'h1);
        chk("d0_instr", instrD, 32'h00A0_0093);
        chk("d0_pcD", pcD, 32'h0);
        chk("d0_pc4", pc_plus4D, 32'h4);
        chk("next_addr", imem.imem_addr, 32'h4);

        step(); step();
        chk("addr8", imem.imem_addr, 32'h8);
        step();
        stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_noreq", {31'b0, imem.imem_req}, 32'h0);
            chk("hold_pcD", pcD, 32'h4);
        end
        stallD = 1'b0;
        #1;
        chk("hold_rel_noreq", {31'b0, imem.imem_req}, 32'h0);
        step();
        chk("hold_pcD8", pcD, 32'h8);
        chk("resume_req", {31'b0, imem.imem_req}, 32'h1);
        chk("resume_addr", imem.imem_addr, 32'hC);

        step(); step();
        chk("addr10", imem.imem_addr, 32'h10);
        mem_lat = 2;
        step();
        br_taken = 1'b1; br_targetE = 32'h100; pend_drop = 1;
        #1;
        chk("br_noreq", {31'b0, imem.imem_req}, 32'h0);
        step();
        br_taken = 1'b0;
        chk("br_flush_valid", {31'b0, validD}, 32'h0);
        #1;
        chk("drop_noreq", {31'b0, imem.imem_req}, 32'h0);
        step();
        chk("drop_valid", {31'b0, validD}, 32'h0);
        chk("tgt_req", {31'b0, imem.imem_req}, 32'h1);
        chk("tgt_addr", imem.imem_addr, 32'h100);
`ifdef RV_FETCH_PERF_EN
        chk("perf_dropped", perf_dropped, 32'h1);
`endif
        mem_lat = 1;
        step(); step();
        chk("tgt_pcD", pcD, 32'h100);

        flushD = 1'b1; stallD = 1'b1;
        step();
        chk("flush_valid", {31'b0, validD}, 32'h0);
        chk("flush_instr", instrD, NOP);
        flushD = 1'b0; stallD = 1'b0;
        step();
        chk("after_flush_pcD", pcD, 32'h104);

        stallF = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stallF_req", {31'b0, imem.imem_req}, 32'h0);
            chk("stallF_addr", imem.imem_addr, 32'h108);
            step();
        end
        stallF = 1'b0;
        #1;
        chk("stallF_rel_req", {31'b0, imem.imem_req}, 32'h1);
        chk("stallF_rel_addr", imem.imem_addr, 32'h108);

        br_taken = 1'b1; br_targetE = 32'hFFFF_FFFC;
        #1;
        chk("br2_noreq", {31'b0, imem.imem_req}, 32'h0);
        step();
        br_taken = 1'b0;
        #1;
        chk("wrap_addr_pre", imem.imem_addr, 32'hFFFF_FFFC);
        step(); step();
        chk("wrap_pcD", pcD, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4D, 32'h0);
        chk("wrap_addr", imem.imem_addr, 32'h0);

        mem_lat = 2;
        step();
        rst = 1'b1; pend_drop = 1;
        #1;
        chk("mid_rst_valid", {31'b0, validD}, 32'h0);
        chk("mid_rst_instr", instrD, NOP);
        chk("mid_rst_pcD", pcD, 32'h0);
        chk("mid_rst_pc4", pc_plus4D, 32'h4);
        chk("mid_rst_req", {31'b0, imem.imem_req}, 32'h0);
        step();
        rst = 1'b0;
        mem_lat = 1;
        #1;
        chk("post_rst_req", {31'b0, imem.imem_req}, 32'h1);
        chk("post_rst_addr", imem.imem_addr, 32'h0);
        step();
        chk("late_rvalid_ignored", {31'b0, validD}, 32'h0);
        step();
        chk("post_rst_pcD", pcD, 32'h0);
        chk("post_rst_instr", instrD, 32'h00A0_0093);
`ifdef RV_FETCH_PERF_EN
        chk("post_rst_perf_f", perf_fetched, 32'h1);
        chk("post_rst_perf_d", perf_dropped, 32'h0);
`endif
        chk("sb_leftover", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
